// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG conditioner: von Neumann state encoding
// and the default configuration constants.
package trng_pkg;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } vn_state_t;

  localparam int DEFAULT_OUT_WIDTH  = 32;
  localparam int DEFAULT_SAMPLE_DIV = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_REP_LIMIT  = 32;

endpackage

// File: rtl/trng_fifo.sv
// Small first-word fall-through FIFO for conditioned TRNG words.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the word is dropped. DEPTH must be a power of two (>=2).
module trng_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign rd_valid = (count != '0);
  assign do_pop   = rd_en && rd_valid;
  assign do_push  = push && ((count != FULL_COUNT) || do_pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only visible through rd_data while valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/trng_conditioner.sv
// TRNG conditioner: decimates the raw TRNG bit stream, removes bias with a
// von Neumann corrector, packs the result into words and queues them in a
// small FIFO. The repetition health test is built only when TRNG_HEALTH_EN
// is defined; otherwise health_fail is tied low and clr_fail is ignored.
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int REP_LIMIT  = DEFAULT_REP_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [OUT_WIDTH-1:0]          raw_in,
  input  logic                          rd_en,
  input  logic                          clr_fail,
  output logic [OUT_WIDTH-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          health_fail
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int BIT_W = $clog2(OUT_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OUT_WIDTH - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic                 sample_tick;
  logic                 sample_bit;
  vn_state_t            state;
  logic                 first_bit;
  logic [OUT_WIDTH-1:0] acc;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 emit;
  logic                 word_done;
  logic [OUT_WIDTH-1:0] push_word;
  logic                 unused_bits;

  assign sample_tick = (div_cnt == DIV_LAST);
  assign sample_bit  = raw_in[0];
  assign unused_bits = ^{raw_in[OUT_WIDTH-1:1], acc[OUT_WIDTH-1]};

  // Sample divider: one raw bit is taken every SAMPLE_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= sample_tick ? '0 : div_cnt + DIV_W'(1);
  end

  // A differing pair emits its first bit (01 -> 0, 10 -> 1).
  assign emit      = sample_tick && (state == SECOND) && (first_bit != sample_bit)
                     && !health_fail;
  assign push_word = {acc[OUT_WIDTH-2:0], first_bit};
  assign word_done = emit && (bit_cnt == BIT_LAST);

`ifdef TRNG_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic             prev_bit;
  logic             fail_q;

  // Next run length of identical samples, saturating at the trip limit.
  always_comb begin
    rep_next = REP_W'(1);
    if ((rep_cnt != '0) && (sample_bit == prev_bit)) begin
      rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + REP_W'(1);
    end
  end

  // Repetition test with a sticky failure flag; a clear beats a trip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt  <= '0;
      prev_bit <= 1'b0;
      fail_q   <= 1'b0;
    end else if (clr_fail) begin
      rep_cnt <= '0;
      fail_q  <= 1'b0;
      if (sample_tick) prev_bit <= sample_bit;
    end else if (sample_tick) begin
      rep_cnt  <= rep_next;
      prev_bit <= sample_bit;
      if (rep_next == REP_MAX) fail_q <= 1'b1;
    end
  end

  assign health_fail = fail_q;
`else
  localparam int unused_rep_limit = REP_LIMIT;
  logic unused_clr;

  assign unused_clr  = clr_fail;
  assign health_fail = 1'b0;
`endif

  // Von Neumann pairing and word accumulation; a failure flushes partial work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FIRST;
      first_bit <= 1'b0;
      acc       <= '0;
      bit_cnt   <= '0;
    end else if (health_fail) begin
      state   <= FIRST;
      acc     <= '0;
      bit_cnt <= '0;
    end else if (sample_tick) begin
      case (state)
        FIRST: begin
          first_bit <= sample_bit;
          state     <= SECOND;
        end
        SECOND: begin
          state <= FIRST;
          if (emit) begin
            acc     <= push_word;
            bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
          end
        end
        default: state <= FIRST;
      endcase
    end
  end

  trng_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_done),
    .push_data (push_word),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (fifo_count)
  );

endmodule
